baser_257b_scrambler: RTL and testbench
=======================================

Name: baser_257b_scrambler

Overview:
Transmit-side scrambler for 257b transcoded blocks. It sits directly downstream of the PCS generator's transcoder output (o_tx_coded_f0) and upstream of the lane distribution and the 257b checker path. The 256-bit payload is scrambled with the self-synchronizing polynomial x^58 + x^39 + 1, and the 1-bit header passes through unchanged. A periodic error injector is included so the downstream 257b checker's invalid-block counting can be exercised.

Parameters:
TC_WIDTH, 257, transcoded block width (header bit + payload).
SH_WIDTH, 1, header width, located at bit 0 and never scrambled.
SCR_WIDTH, 58, scrambler state width.
SCR_TAP, 39, polynomial middle tap (x^39).
SCR_RESET, 58'h3FF_FFFF_FFFF_FFFF, scrambler state after reset.
ERR_CNT_WIDTH, 16, width of the error period counter.

Ports:
clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_valid  in  1  input block valid
i_tx_xcoded  in  TC_WIDTH  257b block; bit0 = header, bits 256:1 = payload
i_bypass  in  1  1: payload passes unscrambled
i_seed_load  in  1  load i_seed into the scrambler state
i_seed  in  SCR_WIDTH  seed value
i_err_en  in  1  enable periodic error injection
i_err_period  in  ERR_CNT_WIDTH  inject on every Nth valid beat; 0 = never
i_err_mask  in  TC_WIDTH  XOR mask applied to the corrupted block
o_valid  out  1  output block valid
o_tx_scrambled  out  TC_WIDTH  scrambled (and possibly corrupted) block
o_err_count  out  32  number of blocks corrupted
o_scr_state  out  SCR_WIDTH  current scrambler state, for debug

Behaviour:
- Reset values (i_rst sampled high at a rising edge):
  - o_valid=0, o_tx_scrambled=0, o_err_count=0.
  - Scrambler state = SCR_RESET; error period counter = 0.
- Latency and valid:
  - Latency is exactly 1 clk: o_valid(t+1) = i_valid(t).
  - o_tx_scrambled updates only on valid beats and holds otherwise.
- Scrambling, bit-serial equivalent evaluated in one cycle:
  - Process payload bits i = 1..256 in order, with st[0] = most recent scrambled bit.
  - s_i = d_i ^ st[SCR_TAP-1] ^ st[SCR_WIDTH-1]; then st = {st[56:0], s_i}.
  - Header bit 0 is copied unchanged.
  - The state advances only on valid beats with i_bypass=0.
- Bypass: payload is copied unchanged and the state is frozen. Leaving bypass resumes from the frozen state.
- Seed load:
  - When i_seed_load=1, the beat in the same cycle (if valid) is scrambled starting from i_seed.
  - The next state is derived from i_seed plus that beat, or equals i_seed if there is no valid beat.
  - i_rst has priority over i_seed_load.
- Error injection:
  - The counter increments on each valid beat while i_err_en=1 and i_err_period!=0.
  - When counter == i_err_period-1:
    - output = scrambled block ^ i_err_mask;
    - counter wraps to 0;
    - o_err_count increments, saturating at 2^32-1.
  - Corruption is applied after scrambling and never feeds back into the scrambler state.
  - i_err_en=0 or i_err_period=0 clears the counter to 0.
  - i_err_period=1 corrupts every valid beat.
- Reset mid-stream: the block in flight is dropped (o_valid=0 next cycle), and the state returns to SCR_RESET.

Decomposition:
- Shared package baser_pkg holds:
  - TC_WIDTH, SH_WIDTH, SCR_WIDTH, SCR_TAP, SCR_RESET;
  - the function scr_step(state, payload) returning {next_state, scrambled_payload}, reused by the bench reference model and a future descrambler.
- One sub-module, baser_err_injector, owns the period counter, the mask XOR and o_err_count.
- The scrambler core stays in the top module.

Test Plan:
1. Reset, then i_bypass=1, i_valid=1, i_tx_xcoded=257'h1_AAAA...AAAA -> the next cycle o_tx_scrambled equals the input, and o_scr_state stays 58'h3FF_FFFF_FFFF_FFFF.
2. Reset state with all-zero payload and header=1, one valid beat -> payload bits 1..39 = 0, payload bit 40 = 1, bit0 = 1; o_valid is high exactly 1 cycle after i_valid.
3. i_seed_load=1 with i_seed=0 and zero payload for 10 valid beats -> every o_tx_scrambled payload is 0.
4. 1000 random valid beats, with i_valid toggled randomly -> output matches the baser_pkg::scr_step model and is recovered exactly by a reference descrambler; bubbles do not advance the state.
5. i_err_en=1, i_err_period=4, i_err_mask=257'h2, 16 valid beats -> beats 4, 8, 12, 16 have bit1 flipped versus the model; o_err_count=4; the checker's o_inv_block_count increments accordingly.
6. Assert i_rst for 1 cycle mid-stream with i_err_period=3 -> next o_valid=0, o_err_count=0, o_scr_state=SCR_RESET, and the counter restarts so the first corruption lands on the 3rd beat after reset.

Source files
------------

// File: rtl/baser_pkg.sv
// Shared constants and the one-cycle parallel form of the x^58 + x^39 + 1 scrambler,
// reused by the 257b scrambler and its matching descrambler.
package baser_pkg;

   localparam int TC_WIDTH      = 257;
   localparam int SH_WIDTH      = 1;
   localparam int PAYLOAD_W     = TC_WIDTH - SH_WIDTH;
   localparam int SCR_WIDTH     = 58;
   localparam int SCR_TAP       = 39;
   localparam int ERR_CNT_WIDTH = 16;
   localparam logic [SCR_WIDTH-1:0] SCR_RESET = 58'h3FF_FFFF_FFFF_FFFF;

   // Returns {next_state, scrambled_payload}; payload[0] is the first bit on the wire,
   // state[0] is the most recently scrambled bit.
   function automatic logic [SCR_WIDTH+PAYLOAD_W-1:0] scr_step(
      input logic [SCR_WIDTH-1:0] state,
      input logic [PAYLOAD_W-1:0] payload
   );
      logic [SCR_WIDTH-1:0] st;
      logic [PAYLOAD_W-1:0] scr;
      logic                 s;
      st  = state;
      scr = '0;
      for (int i = 0; i < PAYLOAD_W; i++) begin
         s      = payload[i] ^ st[SCR_TAP-1] ^ st[SCR_WIDTH-1];
         st     = {st[SCR_WIDTH-2:0], s};
         scr[i] = s;
      end
      return {st, scr};
   endfunction

endpackage

// File: rtl/baser_err_injector.sv
// Periodic block corruptor: XORs a mask onto every Nth valid block and counts the hits.
// Combinational on the block path (registered by the parent); no backpressure, counter/stats update on valid beats.
module baser_err_injector
   import baser_pkg::*;
(
   input  logic                     clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   input  logic                     i_err_en,
   input  logic [ERR_CNT_WIDTH-1:0] i_err_period,
   input  logic [TC_WIDTH-1:0]      i_err_mask,
   input  logic [TC_WIDTH-1:0]      i_block,
   output logic [TC_WIDTH-1:0]      o_block,
   output logic [31:0]              o_err_count
);

   logic [ERR_CNT_WIDTH-1:0] r_cnt;
   logic [31:0]              r_err_count;
   logic                     w_active;
   logic                     w_hit;

   always_comb begin
      w_active = i_err_en && (i_err_period != '0);
      w_hit    = i_valid && w_active && (r_cnt == i_err_period - ERR_CNT_WIDTH'(1));
      o_block  = w_hit ? (i_block ^ i_err_mask) : i_block;
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_cnt       <= '0;
         r_err_count <= '0;
      end else begin
         // Disabling or zeroing the period restarts the phase from scratch.
         if (!w_active)
            r_cnt <= '0;
         else if (i_valid)
            r_cnt <= w_hit ? '0 : r_cnt + ERR_CNT_WIDTH'(1);
         if (w_hit && (r_err_count != '1))
            r_err_count <= r_err_count + 32'd1;
      end
   end

   assign o_err_count = r_err_count;

endmodule

// File: rtl/baser_257b_scrambler.sv
// 257b transmit scrambler (x^58 + x^39 + 1, header bit untouched) with optional error injection.
// Latency 1 clk; no backpressure, every valid beat is accepted and the output holds between beats.
module baser_257b_scrambler
   import baser_pkg::*;
(
   input  logic                     clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   input  logic [TC_WIDTH-1:0]      i_tx_xcoded,
   input  logic                     i_bypass,
   input  logic                     i_seed_load,
   input  logic [SCR_WIDTH-1:0]     i_seed,
   input  logic                     i_err_en,
   input  logic [ERR_CNT_WIDTH-1:0] i_err_period,
   input  logic [TC_WIDTH-1:0]      i_err_mask,
   output logic                     o_valid,
   output logic [TC_WIDTH-1:0]      o_tx_scrambled,
   output logic [31:0]              o_err_count,
   output logic [SCR_WIDTH-1:0]     o_scr_state
);

   logic [SCR_WIDTH-1:0]           r_state;
   logic                           r_valid;
   logic [TC_WIDTH-1:0]            r_block;
   logic [SCR_WIDTH-1:0]           w_base;
   logic [SCR_WIDTH-1:0]           w_next;
   logic [SCR_WIDTH+PAYLOAD_W-1:0] w_step;
   logic [TC_WIDTH-1:0]            w_scr_block;
   logic [TC_WIDTH-1:0]            w_out_block;

   always_comb begin
      // A seed load replaces the state before this cycle's beat is scrambled.
      w_base      = i_seed_load ? i_seed : r_state;
      w_step      = scr_step(w_base, i_tx_xcoded[TC_WIDTH-1:SH_WIDTH]);
      w_next      = w_base;
      w_scr_block = i_tx_xcoded;
      if (!i_bypass) begin
         w_scr_block[TC_WIDTH-1:SH_WIDTH] = w_step[PAYLOAD_W-1:0];
         if (i_valid)
            w_next = w_step[SCR_WIDTH+PAYLOAD_W-1:PAYLOAD_W];
      end
   end

   baser_err_injector u_err_injector (
      .clk          (clk),
      .i_rst        (i_rst),
      .i_valid      (i_valid),
      .i_err_en     (i_err_en),
      .i_err_period (i_err_period),
      .i_err_mask   (i_err_mask),
      .i_block      (w_scr_block),
      .o_block      (w_out_block),
      .o_err_count  (o_err_count)
   );

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_state <= SCR_RESET;
         r_valid <= 1'b0;
         r_block <= '0;
      end else begin
         r_state <= w_next;
         r_valid <= i_valid;
         if (i_valid)
            r_block <= w_out_block;
      end
   end

   assign o_valid        = r_valid;
   assign o_tx_scrambled = r_block;
   assign o_scr_state    = r_state;

endmodule

// File: tb/tb_baser_257b_scrambler.sv
// Bench for baser_257b_scrambler: directed steps plus random traffic against a bit-stream
// model of the scrambler and an independent self-synchronising descrambler.
module tb_baser_257b_scrambler;

   logic           clk = 1'b0;
   logic           i_rst;
   logic           i_valid;
   logic [256:0]   i_tx_xcoded;
   logic           i_bypass;
   logic           i_seed_load;
   logic [57:0]    i_seed;
   logic           i_err_en;
   logic [15:0]    i_err_period;
   logic [256:0]   i_err_mask;
   logic           o_valid;
   logic [256:0]   o_tx_scrambled;
   logic [31:0]    o_err_count;
   logic [57:0]    o_scr_state;

   localparam logic [57:0] RST_STATE = 58'h3FF_FFFF_FFFF_FFFF;

   int          n_checks = 0;
   int          n_fail   = 0;
   bit          hist[$];      // last 58 scrambled bits on the wire, newest at the back
   bit          rxh[$];       // descrambler's view of the received stream
   int          err_beats;
   int unsigned m_err_count;
   logic [256:0] last_out;

   always #5 clk = ~clk;

   baser_257b_scrambler dut (
      .clk            (clk),
      .i_rst          (i_rst),
      .i_valid        (i_valid),
      .i_tx_xcoded    (i_tx_xcoded),
      .i_bypass       (i_bypass),
      .i_seed_load    (i_seed_load),
      .i_seed         (i_seed),
      .i_err_en       (i_err_en),
      .i_err_period   (i_err_period),
      .i_err_mask     (i_err_mask),
      .o_valid        (o_valid),
      .o_tx_scrambled (o_tx_scrambled),
      .o_err_count    (o_err_count),
      .o_scr_state    (o_scr_state)
   );

   task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [256:0] rnd257();
      logic [287:0] t;
      for (int k = 0; k < 9; k++) t[k*32 +: 32] = $urandom();
      return t[256:0];
   endfunction

   // The scrambler state is simply the most recent 58 wire bits, st[0] = newest.
   function automatic logic [57:0] m_state();
      logic [57:0] r;
      for (int k = 0; k < 58; k++) r[k] = hist[57-k];
      return r;
   endfunction

   task automatic m_load(input logic [57:0] s);
      hist = {};
      for (int k = 57; k >= 0; k--) hist.push_back(s[k]);
   endtask

   task automatic m_reset();
      m_load(RST_STATE);
      err_beats   = 0;
      m_err_count = 0;
      last_out    = '0;
   endtask

   // Wire bit n = data bit n ^ wire bit n-39 ^ wire bit n-58.
   task automatic m_scramble(input logic [256:0] blk, output logic [256:0] o);
      bit b;
      o[0] = blk[0];
      for (int i = 1; i <= 256; i++) begin
         b = blk[i] ^ hist[hist.size()-39] ^ hist[hist.size()-58];
         hist.push_back(b);
         void'(hist.pop_front());
         o[i] = b;
      end
   endtask

   task automatic descramble_chk(input string tag, input logic [256:0] rx, input logic [256:0] orig);
      logic [256:0] d;
      d[0] = rx[0];
      for (int i = 1; i <= 256; i++) begin
         d[i] = rx[i] ^ rxh[rxh.size()-39] ^ rxh[rxh.size()-58];
         rxh.push_back(rx[i]);
         void'(rxh.pop_front());
      end
      chk(tag, d, orig);
   endtask

   // One clock: drive, advance the model, then compare everything visible.
   task automatic beat(input string tag, input logic v, input logic [256:0] blk,
                       input logic sl, input logic [57:0] seed);
      logic [256:0] exp;
      i_valid     = v;
      i_tx_xcoded = blk;
      i_seed_load = sl;
      i_seed      = seed;
      if (sl) m_load(seed);
      exp = last_out;
      if (v) begin
         if (i_bypass) exp = blk;
         else m_scramble(blk, exp);
         if (i_err_en && i_err_period != 0) begin
            err_beats++;
            if (err_beats % i_err_period == 0) begin
               exp = exp ^ i_err_mask;
               if (m_err_count != 32'hFFFF_FFFF) m_err_count++;
            end
         end else err_beats = 0;
      end else if (!(i_err_en && i_err_period != 0)) err_beats = 0;
      last_out = exp;
      @(posedge clk); #1;
      chk({tag, "_valid"}, 257'(o_valid), 257'(v));
      chk({tag, "_data"}, o_tx_scrambled, exp);
      chk({tag, "_state"}, 257'(o_scr_state), 257'(m_state()));
      chk({tag, "_errcnt"}, 257'(o_err_count), 257'(m_err_count));
      i_seed_load = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      i_rst = 1'b1;
      @(posedge clk); #1;
      i_rst = 1'b0;
      m_reset();
      chk({tag, "_valid"}, 257'(o_valid), 257'd0);
      chk({tag, "_data"}, o_tx_scrambled, 257'd0);
      chk({tag, "_errcnt"}, 257'(o_err_count), 257'd0);
      chk({tag, "_state"}, 257'(o_scr_state), 257'(RST_STATE));
   endtask

   initial begin
      logic [256:0] blk;
      logic [256:0] b2;
      logic         v;
      i_rst = 1'b1; i_valid = 1'b0; i_tx_xcoded = '0; i_bypass = 1'b0;
      i_seed_load = 1'b0; i_seed = '0; i_err_en = 1'b0; i_err_period = '0; i_err_mask = '0;
      m_reset();
      @(posedge clk); #1;

      // Reset values, with a valid beat presented during reset that must be dropped.
      i_valid = 1'b1; i_tx_xcoded = rnd257();
      do_reset("reset");

      // Bypass: block copied verbatim and state frozen; leaving bypass resumes from it.
      i_bypass = 1'b1;
      blk = {1'b1, {64{4'hA}}};
      beat("bypass", 1'b1, blk, 1'b0, '0);
      chk("bypass_copy", o_tx_scrambled, blk);
      chk("bypass_frozen", 257'(o_scr_state), 257'(RST_STATE));
      i_bypass = 1'b0;
      beat("resume", 1'b1, rnd257(), 1'b0, '0);

      // Zero payload from the reset state: first nonzero wire bit is payload bit 40.
      do_reset("reset2");
      blk = 257'd1;
      beat("zero_pl", 1'b1, blk, 1'b0, '0);
      b2 = o_tx_scrambled;
      chk("zero_pl_low41", 257'(b2[40:0]), 257'(41'h100_0000_0001));
      beat("zero_pl_bubble", 1'b0, blk, 1'b0, '0);

      // Seed of zero with zero payload keeps the wire all-zero.
      for (int n = 0; n < 10; n++) begin
         blk = {256'd0, 1'(n)};
         beat("seed0", 1'b1, blk, (n == 0), '0);
         b2 = o_tx_scrambled;
         chk("seed0_payload", 257'(b2[256:1]), 257'd0);
      end
      // Seed load without a valid beat just sets the state.
      beat("seed_idle", 1'b0, rnd257(), 1'b1, 58'h2AB_CDEF_0123_4567);

      // Random traffic with bubbles, verified by the model and a descrambler.
      do_reset("reset3");
      rxh = {};
      repeat (58) rxh.push_back(1'b1);
      for (int n = 0; n < 1000; n++) begin
         v   = ($urandom_range(0, 3) != 0);
         blk = rnd257();
         beat("rand", v, blk, 1'b0, '0);
         if (v) descramble_chk("descr", o_tx_scrambled, blk);
      end

      // Every 4th valid beat gets bit 1 flipped.
      do_reset("reset4");
      i_err_en = 1'b1; i_err_period = 16'd4; i_err_mask = 257'h2;
      for (int n = 1; n <= 16; n++) begin
         beat("err4", 1'b1, rnd257(), 1'b0, '0);
         if (n % 2 == 0) beat("err4_gap", 1'b0, rnd257(), 1'b0, '0);
      end
      chk("err4_total", 257'(o_err_count), 257'd4);

      // Period 1 corrupts every beat; disabling clears the phase.
      i_err_period = 16'd1; i_err_mask = rnd257();
      for (int n = 0; n < 3; n++) beat("err1", 1'b1, rnd257(), 1'b0, '0);
      i_err_en = 1'b0;
      beat("err_off", 1'b1, rnd257(), 1'b0, '0);

      // Reset mid-stream with period 3: counters restart, 3rd beat after reset is hit.
      i_err_en = 1'b1; i_err_period = 16'd3; i_err_mask = rnd257();
      for (int n = 0; n < 5; n++) beat("pre_rst", 1'b1, rnd257(), 1'b0, '0);
      i_valid = 1'b1; i_tx_xcoded = rnd257();
      do_reset("mid_rst");
      for (int n = 0; n < 3; n++) beat("post_rst", 1'b1, rnd257(), 1'b0, '0);
      chk("post_rst_total", 257'(o_err_count), 257'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
